mul_mac_seq: RTL and testbench
==============================

Name: mul_mac_seq

Overview:
Sequencer that drives the compute-unit multiplier's control port to run an N-term multiply-accumulate into MR without per-term program-sequencer issue. For each term it generates RF read addresses for the Rx/Ry operand vectors and the ps_mul_* controls: clear-product, accumulate add/sub, and an optional final SAT MR. It also collects a sticky overflow flag across the sequence. It sits between the program sequencer and the multiplier, in the same clock domain.

Parameters:
RF_DATASIZE, 16, multiplier data width (documentation only; no datapath here)
ADDR_WIDTH, 4, RF address width
CNT_WIDTH, 4, width of term count

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
seq_start  in  1  start request, sampled in IDLE only
seq_len  in  CNT_WIDTH  number of product terms N
seq_rx_base  in  ADDR_WIDTH  first Rx register address
seq_ry_base  in  ADDR_WIDTH  first Ry register address
seq_dtsts  in  4  data status {ryUbS,rxUbS,IbF,rnd}, passed to ps_mul_dtsts
seq_clr  in  1  1: first term is product (cls 01, overwrites MR); 0: first term accumulates onto MR
seq_sub  in  1  accumulate subtract (cls 11) when 1, add (cls 10) when 0
seq_sat  in  1  append SAT MR step after last term
seq_stall  in  1  suppress issue this cycle
mul_ps_ov  in  1  multiplier overflow flag
seq_busy  out  1  sequence in progress
seq_done  out  1  one-cycle completion pulse
seq_ov  out  1  sticky OR of mul_ps_ov over the sequence
seq_rx_addr  out  ADDR_WIDTH  RF read address, Rx port
seq_ry_addr  out  ADDR_WIDTH  RF read address, Ry port
ps_mul_en  out  1  multiplier enable
ps_mul_otreg  out  1  destination select, always 1 (MR) when enabled
ps_mul_dtsts  out  4  data status
ps_mul_cls  out  2  00 SAT, 01 product, 10 acc add, 11 acc sub

Behaviour:
- Reset (async): state IDLE; cnt=0; all config registers 0; ov_pend=0. Outputs: seq_busy=0, seq_done=0, seq_ov=0, addrs 0, ps_mul_en=0, otreg=0, dtsts=0, cls=00.
- States: IDLE, ISSUE, SATS, DRAIN. Outputs are Moore from state and registers. The only combinational input-to-output path is seq_stall gating ps_mul_en.
- IDLE, seq_start=1:
  - Latch len, bases, dtsts, clr, sub, sat; cnt<=0; seq_ov<=0.
  - Next state is ISSUE if len!=0, else DRAIN.
  - seq_start is ignored in every other state.
- ISSUE:
  - Drives ps_mul_en=~seq_stall, otreg=1, dtsts=latched value.
  - cls=01 if (cnt==0 & clr), else {1,sub}.
  - rx_addr=rx_base+cnt and ry_addr=ry_base+cnt, truncated to ADDR_WIDTH (wraps mod 2^ADDR_WIDTH).
  - If stalled: state, cnt and outputs unchanged except en=0.
  - If not stalled: cnt++. When cnt==len-1 the next state is SATS if sat, else DRAIN.
- SATS: en=~seq_stall, otreg=1, cls=00, dtsts latched (rxUbS selects MR sign). Addresses hold their last value. Stall holds; otherwise go to DRAIN.
- DRAIN: en=0 for one cycle, then IDLE, with seq_done=1 (registered) in the first IDLE cycle.
- seq_busy=1 in ISSUE, SATS and DRAIN; 0 in IDLE, including the done cycle. A new start is accepted in the done cycle.
- Flag collection:
  - ov_pend<=ps_mul_en every cycle.
  - When ov_pend=1, seq_ov<=seq_ov|mul_ps_ov. The multiplier flag is valid the cycle after issue.
  - seq_ov holds after done until the next accepted start.
- Reset mid-sequence: immediate abort; en drops asynchronously; no done pulse. MR contents are not restored.
- ps_mul_en is never 1 in IDLE or DRAIN.

Test Plan:
1. Start at cycle 0 with len=3, rx_base=2, ry_base=5, clr=1, sub=0, sat=0, no stall.
   - Cycles 1-3: en=1, cls=01,10,10; rx=2,3,4; ry=5,6,7.
   - Cycle 4: DRAIN, busy=1.
   - Cycle 5: done=1, busy=0.
2. len=2, clr=0, sub=1, sat=1, dtsts=1110 -> cls=11,11,00 in cycles 1-3; dtsts=1110 and otreg=1 on all; done at cycle 5.
3. Case 1 with stall=1 in cycles 2-3 -> en=1,0,0,1,1 over cycles 1-5; rx=2,3,3,3,4; exactly 3 issues; done at cycle 7.
4. ADDR_WIDTH=4, rx_base=14, len=4 -> rx_addr 14,15,0,1.
5. len=0 -> en never asserted; busy only in cycle 1; done at cycle 2; seq_ov=0.
6. Overflow and reset:
   - Case 1 with mul_ps_ov=1 only in cycle 2 -> seq_ov=1 at done and stays 1. A second start with ov=0 clears it to 0 in the cycle after the start.
   - Assert reset in cycle 2 of a sequence -> en=0, busy=0 immediately; no done pulse.

Source files
------------

// File: rtl/mul_mac_seq.sv
// mul_mac_seq
// Runs an N-term multiply-accumulate into MR by driving the multiplier control
// port once per term. The program sequencer does not issue each term itself.
// For each term the block produces the Rx/Ry register-file read addresses and
// the ps_mul_* controls (clear-product, accumulate add/sub). It can append a
// final SAT MR step. It also collects a sticky multiplier overflow flag for
// the whole sequence.
//
// Ports
//   clk, reset                 clock; asynchronous active-high reset
//   seq_start                  start request, sampled only when idle
//   seq_len                    number of product terms N (0 = no terms)
//   seq_rx_base, seq_ry_base   first Rx / Ry register addresses
//   seq_dtsts                  data status {ryUbS,rxUbS,IbF,rnd}
//   seq_clr                    first term overwrites MR (product) when 1
//   seq_sub                    accumulate subtract when 1, add when 0
//   seq_sat                    append SAT MR after the last term
//   seq_stall                  hold issue for this cycle
//   mul_ps_ov                  multiplier overflow, valid the cycle after issue
//   seq_busy, seq_done         sequence active / one-cycle completion pulse
//   seq_ov                     sticky overflow over the last sequence
//   seq_rx_addr, seq_ry_addr   register-file read addresses
//   ps_mul_en, ps_mul_otreg,
//   ps_mul_dtsts, ps_mul_cls   multiplier control port
module mul_mac_seq #(
  parameter int RF_DATASIZE = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  seq_start,
  input  logic [CNT_WIDTH-1:0]  seq_len,
  input  logic [ADDR_WIDTH-1:0] seq_rx_base,
  input  logic [ADDR_WIDTH-1:0] seq_ry_base,
  input  logic [3:0]            seq_dtsts,
  input  logic                  seq_clr,
  input  logic                  seq_sub,
  input  logic                  seq_sat,
  input  logic                  seq_stall,
  input  logic                  mul_ps_ov,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic                  seq_ov,
  output logic [ADDR_WIDTH-1:0] seq_rx_addr,
  output logic [ADDR_WIDTH-1:0] seq_ry_addr,
  output logic                  ps_mul_en,
  output logic                  ps_mul_otreg,
  output logic [3:0]            ps_mul_dtsts,
  output logic [1:0]            ps_mul_cls
);

  // RF_DATASIZE only documents the multiplier width; reject nonsense values.
  if (RF_DATASIZE < 1) begin : g_bad_datasize
    $error("RF_DATASIZE must be positive");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  localparam logic [1:0] CLS_SAT  = 2'b00;
  localparam logic [1:0] CLS_PROD = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_SATS  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  r_len;
  logic [ADDR_WIDTH-1:0] r_rx_base;
  logic [ADDR_WIDTH-1:0] r_ry_base;
  logic [3:0]            r_dtsts;
  logic                  r_clr;
  logic                  r_sub;
  logic                  r_sat;
  logic                  r_ov_pend;
  logic                  r_ov;
  logic                  r_done;

  logic                  w_last;
  logic                  w_accept;
  logic                  w_en;
  logic [ADDR_WIDTH-1:0] w_rx_cur;
  logic [ADDR_WIDTH-1:0] w_ry_cur;
  logic [ADDR_WIDTH-1:0] w_rx_prev;
  logic [ADDR_WIDTH-1:0] w_ry_prev;

  assign w_accept = (r_state == S_IDLE) && seq_start;
  assign w_last   = (r_cnt == r_len - CNT_ONE);

  // Addresses wrap modulo 2^ADDR_WIDTH. After the last issue cnt == len,
  // so cnt-1 gives the last term's address for the SAT step.
  assign w_rx_cur  = r_rx_base + ADDR_WIDTH'(r_cnt);
  assign w_ry_cur  = r_ry_base + ADDR_WIDTH'(r_cnt);
  assign w_rx_prev = r_rx_base + ADDR_WIDTH'(r_cnt - CNT_ONE);
  assign w_ry_prev = r_ry_base + ADDR_WIDTH'(r_cnt - CNT_ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (seq_start) begin
          w_next = (seq_len != '0) ? S_ISSUE : S_DRAIN;
        end
      end
      S_ISSUE: begin
        if (!seq_stall && w_last) begin
          w_next = r_sat ? S_SATS : S_DRAIN;
        end
      end
      S_SATS: begin
        if (!seq_stall) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_len     <= '0;
      r_rx_base <= '0;
      r_ry_base <= '0;
      r_dtsts   <= '0;
      r_clr     <= 1'b0;
      r_sub     <= 1'b0;
      r_sat     <= 1'b0;
      r_ov_pend <= 1'b0;
      r_ov      <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done    <= (r_state == S_DRAIN);
      // The multiplier reports overflow one cycle after the issue that caused it.
      r_ov_pend <= w_en;
      if (w_accept) begin
        r_len     <= seq_len;
        r_rx_base <= seq_rx_base;
        r_ry_base <= seq_ry_base;
        r_dtsts   <= seq_dtsts;
        r_clr     <= seq_clr;
        r_sub     <= seq_sub;
        r_sat     <= seq_sat;
        r_cnt     <= '0;
        r_ov      <= 1'b0;
      end else begin
        if ((r_state == S_ISSUE) && !seq_stall) begin
          r_cnt <= r_cnt + CNT_ONE;
        end
        if (r_ov_pend) begin
          r_ov <= r_ov | mul_ps_ov;
        end
      end
    end
  end

  // Moore outputs. The stall gating of the enable is the only input-to-output path.
  always_comb begin
    w_en         = 1'b0;
    ps_mul_otreg = 1'b0;
    ps_mul_dtsts = 4'b0000;
    ps_mul_cls   = CLS_SAT;
    seq_rx_addr  = '0;
    seq_ry_addr  = '0;
    case (r_state)
      S_ISSUE: begin
        w_en         = ~seq_stall;
        ps_mul_otreg = 1'b1;
        ps_mul_dtsts = r_dtsts;
        ps_mul_cls   = ((r_cnt == '0) && r_clr) ? CLS_PROD : {1'b1, r_sub};
        seq_rx_addr  = w_rx_cur;
        seq_ry_addr  = w_ry_cur;
      end
      S_SATS: begin
        w_en         = ~seq_stall;
        ps_mul_otreg = 1'b1;
        ps_mul_dtsts = r_dtsts;
        ps_mul_cls   = CLS_SAT;
        seq_rx_addr  = w_rx_prev;
        seq_ry_addr  = w_ry_prev;
      end
      default: begin
        w_en = 1'b0;
      end
    endcase
  end

  assign ps_mul_en = w_en;
  assign seq_busy  = (r_state != S_IDLE);
  assign seq_done  = r_done;
  assign seq_ov    = r_ov;

endmodule

// File: tb/tb_mul_mac_seq.sv
module tb_mul_mac_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       seq_start;
  logic [3:0] seq_len;
  logic [3:0] seq_rx_base;
  logic [3:0] seq_ry_base;
  logic [3:0] seq_dtsts;
  logic       seq_clr;
  logic       seq_sub;
  logic       seq_sat;
  logic       seq_stall;
  logic       mul_ps_ov;
  logic       seq_busy;
  logic       seq_done;
  logic       seq_ov;
  logic [3:0] seq_rx_addr;
  logic [3:0] seq_ry_addr;
  logic       ps_mul_en;
  logic       ps_mul_otreg;
  logic [3:0] ps_mul_dtsts;
  logic [1:0] ps_mul_cls;

  int n_assert = 0;
  int n_fail   = 0;

  mul_mac_seq #(.RF_DATASIZE(16), .ADDR_WIDTH(4), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .seq_start(seq_start), .seq_len(seq_len),
    .seq_rx_base(seq_rx_base), .seq_ry_base(seq_ry_base), .seq_dtsts(seq_dtsts),
    .seq_clr(seq_clr), .seq_sub(seq_sub), .seq_sat(seq_sat),
    .seq_stall(seq_stall), .mul_ps_ov(mul_ps_ov),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_ov(seq_ov),
    .seq_rx_addr(seq_rx_addr), .seq_ry_addr(seq_ry_addr),
    .ps_mul_en(ps_mul_en), .ps_mul_otreg(ps_mul_otreg),
    .ps_mul_dtsts(ps_mul_dtsts), .ps_mul_cls(ps_mul_cls)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // stall_mode: 0 never, 1 random, 2 cycles 2..3 only
  function automatic logic pick_stall(input int mode, input int cyc);
    if (mode == 1) return ($urandom_range(0, 2) == 0);
    if (mode == 2) return (cyc == 2 || cyc == 3);
    return 1'b0;
  endfunction

  // ov_mode: 0 never, 1 random, 2 cycle 2 only
  function automatic logic pick_ov(input int mode, input int cyc);
    if (mode == 1) return ($urandom_range(0, 3) == 0);
    if (mode == 2) return (cyc == 2);
    return 1'b0;
  endfunction

  // One whole sequence. The model is the list of multiplier operations the
  // sequence should produce. The head operation is shown every cycle until an
  // unstalled cycle consumes it. After that come one drain cycle and then the
  // done cycle. Cycle 0 is the cycle where start is driven.
  task automatic run_seq(input logic [3:0] len, input logic [3:0] rxb, input logic [3:0] ryb,
                         input logic [3:0] dt, input logic clr, input logic sub, input logic sat,
                         input int stall_mode, input int ov_mode, input bit chain,
                         output int done_cyc, output int n_en);
    logic [1:0] q_cls[$];
    logic [3:0] q_rx[$];
    logic [3:0] q_ry[$];
    logic exp_ov, prev_en, st, ovi;
    int cyc;
    for (int k = 0; k < int'(len); k++) begin
      q_cls.push_back((k == 0 && clr) ? 2'b01 : {1'b1, sub});
      q_rx.push_back(4'(int'(rxb) + k));
      q_ry.push_back(4'(int'(ryb) + k));
    end
    if (sat && len != 0) begin
      q_cls.push_back(2'b00);
      q_rx.push_back(4'(int'(rxb) + int'(len) - 1));
      q_ry.push_back(4'(int'(ryb) + int'(len) - 1));
    end
    seq_start = 1'b1; seq_len = len; seq_rx_base = rxb; seq_ry_base = ryb;
    seq_dtsts = dt; seq_clr = clr; seq_sub = sub; seq_sat = sat;
    seq_stall = 1'b0; mul_ps_ov = $urandom_range(0, 1);
    @(posedge clk); #1;
    // Scramble the configuration inputs: only the values latched at start may matter.
    seq_start = 1'b0; seq_len = 4'($urandom); seq_rx_base = 4'($urandom);
    seq_ry_base = 4'($urandom); seq_dtsts = 4'($urandom); seq_clr = 1'($urandom);
    seq_sub = 1'($urandom); seq_sat = 1'($urandom);
    exp_ov = 1'b0; prev_en = 1'b0; cyc = 1; n_en = 0;
    while (q_cls.size() > 0 && cyc < 64) begin
      st = pick_stall(stall_mode, cyc); ovi = pick_ov(ov_mode, cyc);
      seq_stall = st; mul_ps_ov = ovi;
      @(negedge clk);
      chk("issue_en", ps_mul_en, !st);
      chk("issue_busy", seq_busy, 1'b1);
      chk("issue_done", seq_done, 1'b0);
      chk("issue_cls", ps_mul_cls, q_cls[0]);
      chk("issue_rx", seq_rx_addr, q_rx[0]);
      chk("issue_ry", seq_ry_addr, q_ry[0]);
      chk("issue_otreg", ps_mul_otreg, 1'b1);
      chk("issue_dtsts", ps_mul_dtsts, dt);
      chk("issue_ov", seq_ov, exp_ov);
      if (ps_mul_en === 1'b1) n_en++;
      @(posedge clk); #1;
      if (prev_en && ovi) exp_ov = 1'b1;
      prev_en = !st;
      if (!st) begin
        void'(q_cls.pop_front()); void'(q_rx.pop_front()); void'(q_ry.pop_front());
      end
      cyc++;
    end
    // drain cycle
    st = pick_stall(stall_mode, cyc); ovi = pick_ov(ov_mode, cyc);
    seq_stall = st; mul_ps_ov = ovi;
    @(negedge clk);
    chk("drain_en", ps_mul_en, 1'b0);
    chk("drain_busy", seq_busy, 1'b1);
    chk("drain_done", seq_done, 1'b0);
    chk("drain_ov", seq_ov, exp_ov);
    @(posedge clk); #1;
    if (prev_en && ovi) exp_ov = 1'b1;
    cyc++;
    // done cycle
    seq_stall = 1'($urandom); mul_ps_ov = 1'($urandom);
    @(negedge clk);
    chk("done_pulse", seq_done, 1'b1);
    chk("done_busy", seq_busy, 1'b0);
    chk("done_en", ps_mul_en, 1'b0);
    chk("done_ov", seq_ov, exp_ov);
    done_cyc = cyc;
    if (!chain) begin
      @(posedge clk); #1;
      mul_ps_ov = 1'b1; seq_stall = 1'b0;
      @(negedge clk);
      chk("post_done", seq_done, 1'b0);
      chk("post_busy", seq_busy, 1'b0);
      chk("post_en", ps_mul_en, 1'b0);
      chk("post_ov_hold", seq_ov, exp_ov);
    end
  endtask

  initial begin
    int dc, ne;
    reset = 1'b1; seq_start = 1'b0; seq_len = 4'd0; seq_rx_base = 4'd0; seq_ry_base = 4'd0;
    seq_dtsts = 4'd0; seq_clr = 1'b0; seq_sub = 1'b0; seq_sat = 1'b0;
    seq_stall = 1'b0; mul_ps_ov = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", seq_busy, 1'b0);
    chk("rst_done", seq_done, 1'b0);
    chk("rst_ov", seq_ov, 1'b0);
    chk("rst_rx", seq_rx_addr, 4'd0);
    chk("rst_ry", seq_ry_addr, 4'd0);
    chk("rst_en", ps_mul_en, 1'b0);
    chk("rst_otreg", ps_mul_otreg, 1'b0);
    chk("rst_dtsts", ps_mul_dtsts, 4'd0);
    chk("rst_cls", ps_mul_cls, 2'b00);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: basic product + accumulate
    run_seq(4'd3, 4'd2, 4'd5, 4'b0000, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, dc, ne);
    chk("t1_done_cycle", 8'(dc), 8'd5);
    chk("t1_issues", 8'(ne), 8'd3);
    // 2: accumulate subtract with SAT step
    run_seq(4'd2, 4'd0, 4'd8, 4'b1110, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, dc, ne);
    chk("t2_done_cycle", 8'(dc), 8'd5);
    chk("t2_issues", 8'(ne), 8'd3);
    // 3: stall in cycles 2-3
    run_seq(4'd3, 4'd2, 4'd5, 4'b0000, 1'b1, 1'b0, 1'b0, 2, 0, 1'b0, dc, ne);
    chk("t3_done_cycle", 8'(dc), 8'd7);
    chk("t3_issues", 8'(ne), 8'd3);
    // 4: address wrap
    run_seq(4'd4, 4'd14, 4'd13, 4'b0101, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, dc, ne);
    chk("t4_issues", 8'(ne), 8'd4);
    // 5: zero-length sequence, with sat requested
    run_seq(4'd0, 4'd3, 4'd3, 4'b1111, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, dc, ne);
    chk("t5_done_cycle", 8'(dc), 8'd2);
    chk("t5_issues", 8'(ne), 8'd0);
    chk("t5_ov", seq_ov, 1'b0);
    // 6a: overflow after first issue is sticky, then cleared by the next start
    run_seq(4'd3, 4'd2, 4'd5, 4'b0000, 1'b1, 1'b0, 1'b0, 0, 2, 1'b0, dc, ne);
    chk("t6_ov_sticky", seq_ov, 1'b1);
    run_seq(4'd2, 4'd1, 4'd1, 4'b0000, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, dc, ne);
    chk("t6_ov_cleared", seq_ov, 1'b0);

    // 6b: reset in cycle 2 of a sequence
    seq_start = 1'b1; seq_len = 4'd3; seq_rx_base = 4'd2; seq_ry_base = 4'd5;
    seq_clr = 1'b1; seq_sub = 1'b0; seq_sat = 1'b0; seq_stall = 1'b0; mul_ps_ov = 1'b0;
    @(posedge clk); #1;
    seq_start = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_pre_en", ps_mul_en, 1'b1);
    reset = 1'b1;
    #1;
    chk("rstmid_en", ps_mul_en, 1'b0);
    chk("rstmid_busy", seq_busy, 1'b0);
    chk("rstmid_otreg", ps_mul_otreg, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstmid_no_done", seq_done, 1'b0);
      chk("rstmid_idle", seq_busy, 1'b0);
    end

    // randomized sequences, some started in the done cycle of the previous one
    for (int i = 0; i < 40; i++) begin
      logic [3:0] l;
      l = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
      run_seq(l, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1, 1, bit'($urandom_range(0, 1)), dc, ne);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
